hpu_task_dispatcher: RTL and testbench
======================================

HPU_TASK_DISPATCHER -- requirements
Module: hpu_task_dispatcher

Interface
REQ-001 Parameter: NUM_HPUS, default 8, number of HPU task slots in one cluster (power of two, >=2).
REQ-002 Parameter: TASK_W, default 64, width of the opaque task descriptor.
REQ-003 Parameter: FB_W, default 32, width of the opaque feedback descriptor.
REQ-004 The block has one clock, and its reset is synchronous and active-high.
REQ-005 clk_i  in  1  clock.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 task_valid_i / task_ready_o / task_descr_i  in/out/in  1/1/TASK_W  upstream task handshake.
REQ-008 hpu_task_valid_o / hpu_task_ready_i / hpu_task_descr_o  out/in/out  NUM_HPUS/NUM_HPUS/NUM_HPUS*TASK_W  per-HPU task issue.
REQ-009 hpu_done_valid_i / hpu_done_ready_o / hpu_done_descr_i  in/out/in  NUM_HPUS/NUM_HPUS/NUM_HPUS*FB_W  per-HPU completion.
REQ-010 feedback_valid_o / feedback_ready_i / feedback_descr_o  out/in/out  1/1/FB_W  merged completion stream to the upstream scheduler.
REQ-011 hpu_enable_i  in  NUM_HPUS  configuration mask; 0 excludes the HPU from new selections.
REQ-012 busy_o  out  NUM_HPUS  per-HPU reservation bitmap.
REQ-013 free_count_o  out  clog2(NUM_HPUS)+1  popcount(hpu_enable_i & ~busy_o), combinational.
REQ-014 err_o  out  1  sticky flag: a completion arrived from a non-busy HPU.

Function
REQ-015 Dispatch FSM states: IDLE and ISSUE.
REQ-016 IDLE: task_ready_o=1 iff at least one HPU has hpu_enable_i=1 and busy=0; task_ready_o=0 in ISSUE.
REQ-017 On accept (valid&ready in IDLE): latch descriptor; select target = first eligible HPU at or after rr pointer (wrap modulo NUM_HPUS); set busy[target]; rr pointer <= target+1 (wrap); go to ISSUE.
REQ-018 ISSUE: hpu_task_valid_o[target]=1, all other bits 0; hpu_task_descr_o[target] = latched descriptor; go to IDLE on hpu_task_ready_i[target].
REQ-019 Latency: accept in cycle N -> hpu_task_valid_o asserted in cycle N+1; back-to-back accept no sooner than the cycle after the issue handshake.
REQ-020 hpu_task_valid_o and hpu_task_descr_o stay stable while waiting for ready.
REQ-021 Deasserting hpu_enable_i affects only future selections; in-flight ISSUE and busy bits are unaffected.
REQ-022 Completion arbiter: round-robin over hpu_done_valid_i, starting after the last granted index.
REQ-023 Output register: one entry; hpu_done_ready_o[g]=1 for the granted HPU only when the register is empty or is being drained this cycle (feedback_ready_i=1).
REQ-024 A completion handshake in cycle N -> feedback_valid_o with that descriptor in cycle N+1; feedback_valid_o/descr held until feedback_ready_i.
REQ-025 A completion handshake from HPU i clears busy[i]; the freed slot becomes selectable in the next cycle.
REQ-026 Completion from HPU i with busy[i]=0: still forwarded, busy unchanged, err_o set until reset.
REQ-027 Reservation for HPU i and completion for HPU j in the same cycle are both applied; i==j cannot occur (a reserved HPU was free).
REQ-028 All eligible HPUs busy: task_ready_o=0, and upstream stalls without loss.

Reset
REQ-029 While rst_i=1 at a clock edge: FSM->IDLE, busy=0, both rr pointers=0, output register empty, err_o=0; all valid/ready outputs 0 during reset.
REQ-030 Reset during ISSUE drops the latched task; there is no retry.

Verification
REQ-031 NUM_HPUS=4, all enabled, 5 tasks back-to-back, hpu ready=1, no completions -> issued to HPUs 0,1,2,3; task_ready_o=0 for the 5th; free_count_o=0; busy_o=4'b1111.
REQ-032 From the previous state, done on HPU 2 with descr 0xA5, feedback_ready_i=1 -> feedback_valid_o with 0xA5 next cycle; busy_o=4'b1011; the 5th task is then issued to HPU 2.
REQ-033 hpu_enable_i=4'b1010, 2 tasks -> issued to HPUs 1 and 3 only; the 3rd task stalls.
REQ-034 Simultaneous done on HPUs 0,1,3 with feedback_ready_i held 0 for 3 cycles then 1 -> outputs in order 0,1,3; no descriptor lost; each hpu_done_ready_o is a single-cycle pulse.
REQ-035 hpu_task_ready_i[0]=0 for 4 cycles in ISSUE -> valid/descr stable for 5 cycles; task_ready_o=0 throughout.
REQ-036 Done on a non-busy HPU -> err_o=1 and sticky; feedback is forwarded; rst_i pulse -> err_o=0, busy_o=0, FSM IDLE.

Source files
------------

// File: rtl/hpu_task_dispatcher.sv
// Cluster task dispatcher: hands upstream tasks to free HPUs round-robin and
// merges per-HPU completions into one registered feedback stream.
module hpu_task_dispatcher #(
    parameter int unsigned NUM_HPUS = 8,
    parameter int unsigned TASK_W   = 64,
    parameter int unsigned FB_W     = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,

    input  logic                         task_valid_i,
    output logic                         task_ready_o,
    input  logic [TASK_W-1:0]            task_descr_i,

    output logic [NUM_HPUS-1:0]          hpu_task_valid_o,
    input  logic [NUM_HPUS-1:0]          hpu_task_ready_i,
    output logic [NUM_HPUS*TASK_W-1:0]   hpu_task_descr_o,

    input  logic [NUM_HPUS-1:0]          hpu_done_valid_i,
    output logic [NUM_HPUS-1:0]          hpu_done_ready_o,
    input  logic [NUM_HPUS*FB_W-1:0]     hpu_done_descr_i,

    output logic                         feedback_valid_o,
    input  logic                         feedback_ready_i,
    output logic [FB_W-1:0]              feedback_descr_o,

    input  logic [NUM_HPUS-1:0]          hpu_enable_i,
    output logic [NUM_HPUS-1:0]          busy_o,
    output logic [$clog2(NUM_HPUS):0]    free_count_o,
    output logic                         err_o
);

    localparam int unsigned IDX_W = $clog2(NUM_HPUS);
    localparam int unsigned CNT_W = $clog2(NUM_HPUS) + 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_e;

    state_e              state_q;
    logic [IDX_W-1:0]    task_rr_q;
    logic [IDX_W-1:0]    done_rr_q;
    logic [IDX_W-1:0]    target_q;
    logic [TASK_W-1:0]   descr_q;
    logic [NUM_HPUS-1:0] busy_q;
    logic                fb_valid_q;
    logic [FB_W-1:0]     fb_descr_q;
    logic                err_q;

    logic [NUM_HPUS-1:0] eligible;
    logic                sel_found;
    logic [IDX_W-1:0]    sel_idx;
    logic [IDX_W-1:0]    sel_cand;
    logic                grant_found;
    logic [IDX_W-1:0]    grant_idx;
    logic [IDX_W-1:0]    grant_cand;
    logic [FB_W-1:0]     done_descr_sel;
    logic [CNT_W-1:0]    free_cnt;
    logic [NUM_HPUS-1:0] busy_d;
    logic                task_fire;
    logic                can_take;
    logic                done_fire;

    assign eligible = hpu_enable_i & ~busy_q;

    // First eligible HPU at or after the task pointer; index arithmetic wraps naturally.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_cand  = '0;
        for (int unsigned k = 0; k < NUM_HPUS; k++) begin
            sel_cand = task_rr_q + IDX_W'(k);
            if (!sel_found && eligible[sel_cand]) begin
                sel_found = 1'b1;
                sel_idx   = sel_cand;
            end
        end
    end

    // Completion grant: first requesting HPU at or after the completion pointer.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_cand  = '0;
        for (int unsigned k = 0; k < NUM_HPUS; k++) begin
            grant_cand = done_rr_q + IDX_W'(k);
            if (!grant_found && hpu_done_valid_i[grant_cand]) begin
                grant_found = 1'b1;
                grant_idx   = grant_cand;
            end
        end
    end

    always_comb begin
        done_descr_sel = '0;
        for (int unsigned i = 0; i < NUM_HPUS; i++) begin
            if (IDX_W'(i) == grant_idx) begin
                done_descr_sel = hpu_done_descr_i[i*FB_W +: FB_W];
            end
        end
    end

    always_comb begin
        free_cnt = '0;
        for (int unsigned i = 0; i < NUM_HPUS; i++) begin
            free_cnt = free_cnt + CNT_W'(eligible[i]);
        end
    end

    assign task_ready_o = !rst_i && (state_q == S_IDLE) && sel_found;
    assign task_fire    = task_valid_i && task_ready_o;
    assign can_take     = !fb_valid_q || feedback_ready_i;
    assign done_fire    = !rst_i && grant_found && can_take;

    always_comb begin
        hpu_done_ready_o = '0;
        if (done_fire) begin
            hpu_done_ready_o[grant_idx] = 1'b1;
        end
    end

    // A stray completion on a free HPU must not cancel a reservation made the same cycle.
    always_comb begin
        busy_d = busy_q;
        if (done_fire && busy_q[grant_idx]) begin
            busy_d[grant_idx] = 1'b0;
        end
        if (task_fire) begin
            busy_d[sel_idx] = 1'b1;
        end
    end

    always_comb begin
        hpu_task_valid_o = '0;
        hpu_task_descr_o = '0;
        for (int unsigned i = 0; i < NUM_HPUS; i++) begin
            if (!rst_i && (state_q == S_ISSUE) && (IDX_W'(i) == target_q)) begin
                hpu_task_valid_o[i]                 = 1'b1;
                hpu_task_descr_o[i*TASK_W +: TASK_W] = descr_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            task_rr_q  <= '0;
            done_rr_q  <= '0;
            target_q   <= '0;
            busy_q     <= '0;
            fb_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            busy_q <= busy_d;
            case (state_q)
                S_IDLE: begin
                    if (task_fire) begin
                        target_q  <= sel_idx;
                        descr_q   <= task_descr_i;
                        task_rr_q <= sel_idx + IDX_W'(1);
                        state_q   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (hpu_task_ready_i[target_q]) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (done_fire) begin
                fb_valid_q <= 1'b1;
                fb_descr_q <= done_descr_sel;
                done_rr_q  <= grant_idx + IDX_W'(1);
                if (!busy_q[grant_idx]) begin
                    err_q <= 1'b1;
                end
            end else if (feedback_ready_i) begin
                fb_valid_q <= 1'b0;
            end
        end
    end

    assign busy_o           = busy_q;
    assign free_count_o     = free_cnt;
    assign feedback_valid_o = fb_valid_q && !rst_i;
    assign feedback_descr_o = fb_descr_q;
    assign err_o            = err_q;

endmodule

// File: tb/tb_hpu_task_dispatcher.sv
// Randomized self-checking bench for hpu_task_dispatcher (4 HPUs) against a
// slot/pointer reference model derived from the dispatch and completion rules.
module tb_hpu_task_dispatcher;

    localparam int N  = 4;
    localparam int TW = 64;
    localparam int FW = 32;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            task_valid_i;
    logic            task_ready_o;
    logic [TW-1:0]   task_descr_i;
    logic [N-1:0]    hpu_task_valid_o;
    logic [N-1:0]    hpu_task_ready_i;
    logic [N*TW-1:0] hpu_task_descr_o;
    logic [N-1:0]    hpu_done_valid_i;
    logic [N-1:0]    hpu_done_ready_o;
    logic [N*FW-1:0] hpu_done_descr_i;
    logic            feedback_valid_o;
    logic            feedback_ready_i;
    logic [FW-1:0]   feedback_descr_o;
    logic [N-1:0]    hpu_enable_i;
    logic [N-1:0]    busy_o;
    logic [2:0]      free_count_o;
    logic            err_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [N-1:0] m_busy;
    int           m_rr;

    hpu_task_dispatcher #(.NUM_HPUS(N), .TASK_W(TW), .FB_W(FW)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .task_valid_i     (task_valid_i),
        .task_ready_o     (task_ready_o),
        .task_descr_i     (task_descr_i),
        .hpu_task_valid_o (hpu_task_valid_o),
        .hpu_task_ready_i (hpu_task_ready_i),
        .hpu_task_descr_o (hpu_task_descr_o),
        .hpu_done_valid_i (hpu_done_valid_i),
        .hpu_done_ready_o (hpu_done_ready_o),
        .hpu_done_descr_i (hpu_done_descr_i),
        .feedback_valid_o (feedback_valid_o),
        .feedback_ready_i (feedback_ready_i),
        .feedback_descr_o (feedback_descr_o),
        .hpu_enable_i     (hpu_enable_i),
        .busy_o           (busy_o),
        .free_count_o     (free_count_o),
        .err_o            (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got timeout, need completion)");
        $fatal(1, "watchdog");
    end

    function automatic int pick(input logic [N-1:0] en, input logic [N-1:0] busy, input int rr);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (rr + k) % N;
            if (en[idx] && !busy[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int popc(input logic [N-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < N; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        if (popc(v) != 1) return -1;
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [TW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic do_reset();
        @(negedge clk_i);
        rst_i            = 1'b1;
        task_valid_i     = 1'b0;
        task_descr_i     = '0;
        hpu_task_ready_i = '1;
        hpu_done_valid_i = '0;
        hpu_done_descr_i = '0;
        feedback_ready_i = 1'b1;
        hpu_enable_i     = '1;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i  = 1'b0;
        m_busy = '0;
        m_rr   = 0;
    endtask

    // Offers one task for a single cycle; reports whether it was taken and where it went.
    task automatic issue_task(input logic [TW-1:0] d, output logic rdy, output int tgt,
                              output logic [TW-1:0] got);
        @(negedge clk_i);
        task_valid_i = 1'b1;
        task_descr_i = d;
        #1 rdy = task_ready_o;
        @(negedge clk_i);
        task_valid_i = 1'b0;
        #1 tgt = onehot_idx(hpu_task_valid_o);
        got = (tgt >= 0) ? hpu_task_descr_o[tgt*TW +: TW] : '0;
    endtask

    task automatic test_reset();
        rst_i            = 1'b1;
        task_valid_i     = 1'b1;
        task_descr_i     = '0;
        hpu_task_ready_i = '1;
        hpu_done_valid_i = '1;
        hpu_done_descr_i = '0;
        feedback_ready_i = 1'b1;
        hpu_enable_i     = '1;
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        n_tests++;
        if ({task_ready_o, hpu_done_ready_o, feedback_valid_o, hpu_task_valid_o} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b done_rdy=%b fbv=%b tv=%b, need all 0",
                     task_ready_o, hpu_done_ready_o, feedback_valid_o, hpu_task_valid_o);
        end
        @(negedge clk_i);
        rst_i            = 1'b0;
        task_valid_i     = 1'b0;
        hpu_done_valid_i = '0;
        m_busy = '0;
        m_rr   = 0;
        #1;
        n_tests++;
        if ({busy_o, err_o, free_count_o, task_ready_o} !== {4'b0, 1'b0, 3'd4, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b err=%b free=%0d rdy=%b, need 0000 0 4 1",
                     busy_o, err_o, free_count_o, task_ready_o);
        end
    endtask

    task automatic test_fill_and_free();
        logic          rdy;
        int            tgt, exp;
        logic [TW-1:0] d, got, d5;
        do_reset();
        for (int i = 0; i < N; i++) begin
            d   = rnd64();
            exp = pick(hpu_enable_i, m_busy, m_rr);
            issue_task(d, rdy, tgt, got);
            n_tests++;
            if (!rdy || tgt !== exp || got !== d) begin
                n_fail++;
                $display("FAIL fill_issue%0d: got rdy=%b hpu=%0d descr=%h, need 1 %0d %h",
                         i, rdy, tgt, got, exp, d);
            end
            m_busy[exp] = 1'b1;
            m_rr        = (exp + 1) % N;
        end
        d5 = rnd64();
        @(negedge clk_i);
        task_valid_i = 1'b1;
        task_descr_i = d5;
        #1;
        n_tests++;
        if (task_ready_o !== 1'b0 || free_count_o !== 3'd0 || busy_o !== 4'b1111) begin
            n_fail++;
            $display("FAIL fill_full: got rdy=%b free=%0d busy=%b, need 0 0 1111",
                     task_ready_o, free_count_o, busy_o);
        end
        @(negedge clk_i);
        hpu_done_valid_i         = 4'b0100;
        hpu_done_descr_i[2*FW +: FW] = 32'hA5;
        feedback_ready_i         = 1'b1;
        #1;
        n_tests++;
        if (hpu_done_ready_o !== 4'b0100 || task_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL free_handshake: got done_rdy=%b task_rdy=%b, need 0100 0",
                     hpu_done_ready_o, task_ready_o);
        end
        @(negedge clk_i);
        hpu_done_valid_i = '0;
        m_busy[2] = 1'b0;
        exp = pick(hpu_enable_i, m_busy, m_rr);
        #1;
        n_tests++;
        if (feedback_valid_o !== 1'b1 || feedback_descr_o !== 32'hA5 || busy_o !== 4'b1011 ||
            task_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL free_feedback: got fbv=%b fb=%h busy=%b rdy=%b, need 1 a5 1011 1",
                     feedback_valid_o, feedback_descr_o, busy_o, task_ready_o);
        end
        @(negedge clk_i);
        task_valid_i = 1'b0;
        #1;
        n_tests++;
        if (onehot_idx(hpu_task_valid_o) !== exp || exp !== 2 ||
            hpu_task_descr_o[2*TW +: TW] !== d5) begin
            n_fail++;
            $display("FAIL fifth_task: got valid=%b descr=%h, need hpu 2 descr %h",
                     hpu_task_valid_o, hpu_task_descr_o[2*TW +: TW], d5);
        end
        m_busy[2] = 1'b1;
        m_rr      = 3;
    endtask

    task automatic test_enable_mask();
        logic          rdy;
        int            tgt, exp;
        logic [TW-1:0] d, got;
        do_reset();
        hpu_enable_i = 4'b1010;
        for (int i = 0; i < 2; i++) begin
            d   = rnd64();
            exp = pick(hpu_enable_i, m_busy, m_rr);
            issue_task(d, rdy, tgt, got);
            n_tests++;
            if (!rdy || tgt !== exp || got !== d || tgt !== (2 * i + 1)) begin
                n_fail++;
                $display("FAIL mask_issue%0d: got rdy=%b hpu=%0d, need 1 %0d", i, rdy, tgt, 2 * i + 1);
            end
            m_busy[exp] = 1'b1;
            m_rr        = (exp + 1) % N;
        end
        @(negedge clk_i);
        task_valid_i = 1'b1;
        #1;
        n_tests++;
        if (task_ready_o !== 1'b0 || free_count_o !== 3'd0 || busy_o !== 4'b1010) begin
            n_fail++;
            $display("FAIL mask_stall: got rdy=%b free=%0d busy=%b, need 0 0 1010",
                     task_ready_o, free_count_o, busy_o);
        end
        @(negedge clk_i);
        task_valid_i = 1'b0;
        hpu_enable_i = '1;
    endtask

    task automatic test_done_merge();
        logic          rdy;
        int            tgt, ptr, g;
        logic [TW-1:0] got;
        logic [FW-1:0] dd [N];
        logic [N-1:0]  pend, clr;
        int            pulses [N];
        int            exp_order [$];
        logic [FW-1:0] seen [$];
        do_reset();
        for (int i = 0; i < N; i++) issue_task(rnd64(), rdy, tgt, got);
        for (int i = 0; i < N; i++) begin
            dd[i]     = $urandom;
            pulses[i] = 0;
            hpu_done_descr_i[i*FW +: FW] = dd[i];
        end
        pend = 4'b1011;
        ptr  = 0;
        repeat (3) begin
            g = pick(pend, 4'b0000, ptr);
            exp_order.push_back(g);
            pend[g] = 1'b0;
            ptr = (g + 1) % N;
        end
        hpu_done_valid_i = 4'b1011;
        clr = '0;
        for (int cyc = 0; cyc < 20 && seen.size() < 3; cyc++) begin
            @(negedge clk_i);
            hpu_done_valid_i = hpu_done_valid_i & ~clr;
            feedback_ready_i = (cyc >= 3);
            #1;
            if (cyc == 1 || cyc == 2) begin
                n_tests++;
                if (feedback_valid_o !== 1'b1 || feedback_descr_o !== dd[exp_order[0]]) begin
                    n_fail++;
                    $display("FAIL merge_hold_c%0d: got fbv=%b fb=%h, need 1 %h",
                             cyc, feedback_valid_o, feedback_descr_o, dd[exp_order[0]]);
                end
            end
            if (feedback_valid_o && feedback_ready_i) seen.push_back(feedback_descr_o);
            clr = hpu_done_ready_o & hpu_done_valid_i;
            for (int i = 0; i < N; i++) pulses[i] += int'(hpu_done_ready_o[i]);
        end
        hpu_done_valid_i = '0;
        feedback_ready_i = 1'b1;
        n_tests++;
        if (seen.size() != 3) begin
            n_fail++;
            $display("FAIL merge_count: got %0d feedback beats, need 3", seen.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (seen[k] !== dd[exp_order[k]]) begin
                    n_fail++;
                    $display("FAIL merge_order%0d: got %h, need %h (hpu %0d)",
                             k, seen[k], dd[exp_order[k]], exp_order[k]);
                end
            end
        end
        n_tests++;
        if (pulses[0] != 1 || pulses[1] != 1 || pulses[2] != 0 || pulses[3] != 1) begin
            n_fail++;
            $display("FAIL merge_pulses: got %0d %0d %0d %0d ready cycles, need 1 1 0 1",
                     pulses[0], pulses[1], pulses[2], pulses[3]);
        end
        #1;
        n_tests++;
        if (busy_o !== 4'b0100 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL merge_busy: got busy=%b err=%b, need 0100 0", busy_o, err_o);
        end
    endtask

    task automatic test_issue_stall();
        logic [TW-1:0] d;
        do_reset();
        d = rnd64();
        @(negedge clk_i);
        hpu_task_ready_i = '0;
        task_valid_i     = 1'b1;
        task_descr_i     = d;
        #1;
        n_tests++;
        if (task_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_accept: got rdy=%b, need 1", task_ready_o);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            task_descr_i = rnd64();
            if (c == 4) hpu_task_ready_i = 4'b0001;
            #1;
            n_tests++;
            if (hpu_task_valid_o !== 4'b0001 || hpu_task_descr_o[TW-1:0] !== d || task_ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold_c%0d: got valid=%b descr=%h rdy=%b, need 0001 %h 0",
                         c, hpu_task_valid_o, hpu_task_descr_o[TW-1:0], task_ready_o, d);
            end
        end
        @(negedge clk_i);
        task_valid_i     = 1'b0;
        hpu_task_ready_i = '1;
        #1;
        n_tests++;
        if (hpu_task_valid_o !== 4'b0000 || busy_o !== 4'b0001 || task_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: got valid=%b busy=%b rdy=%b, need 0000 0001 1",
                     hpu_task_valid_o, busy_o, task_ready_o);
        end
    endtask

    task automatic test_err_sticky();
        logic [FW-1:0] fd;
        do_reset();
        fd = $urandom;
        @(negedge clk_i);
        hpu_done_valid_i = 4'b0010;
        hpu_done_descr_i[1*FW +: FW] = fd;
        #1;
        n_tests++;
        if (hpu_done_ready_o !== 4'b0010) begin
            n_fail++;
            $display("FAIL err_handshake: got done_rdy=%b, need 0010", hpu_done_ready_o);
        end
        @(negedge clk_i);
        hpu_done_valid_i = '0;
        #1;
        n_tests++;
        if (feedback_valid_o !== 1'b1 || feedback_descr_o !== fd || err_o !== 1'b1 || busy_o !== 4'b0) begin
            n_fail++;
            $display("FAIL err_set: got fbv=%b fb=%h err=%b busy=%b, need 1 %h 1 0000",
                     feedback_valid_o, feedback_descr_o, err_o, busy_o, fd);
        end
        repeat (3) @(negedge clk_i);
        #1;
        n_tests++;
        if (err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got err=%b, need 1", err_o);
        end
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        m_busy = '0;
        m_rr   = 0;
        #1;
        n_tests++;
        if (err_o !== 1'b0 || busy_o !== 4'b0 || task_ready_o !== 1'b1 || hpu_task_valid_o !== 4'b0) begin
            n_fail++;
            $display("FAIL err_clear: got err=%b busy=%b rdy=%b tv=%b, need 0 0000 1 0000",
                     err_o, busy_o, task_ready_o, hpu_task_valid_o);
        end
    endtask

    // Random tasks, masks and completions, including reserve and release in one cycle.
    task automatic test_random();
        logic [N-1:0]  en;
        logic          want_task, want_done, acc, exp_rdy;
        int            j, t;
        logic [TW-1:0] d;
        logic [FW-1:0] fd;
        do_reset();
        for (int it = 0; it < 60; it++) begin
            @(negedge clk_i);
            en = 4'($urandom_range(1, 15));
            hpu_enable_i = en;
            want_task = ($urandom_range(0, 3) != 0);
            want_done = (m_busy != 0) && ($urandom_range(0, 1) == 1);
            j = -1;
            if (want_done) begin
                j = $urandom_range(0, N - 1);
                while (!m_busy[j]) j = (j + 1) % N;
                fd = $urandom;
                hpu_done_descr_i[j*FW +: FW] = fd;
                hpu_done_valid_i[j] = 1'b1;
            end
            d = rnd64();
            task_valid_i = want_task;
            task_descr_i = d;
            #1;
            exp_rdy = ((en & ~m_busy) != 0);
            t = pick(en, m_busy, m_rr);
            acc = want_task && exp_rdy;
            n_tests++;
            if (task_ready_o !== exp_rdy || free_count_o !== 3'(popc(en & ~m_busy)) ||
                (want_done && hpu_done_ready_o !== 4'(1 << j))) begin
                n_fail++;
                $display("FAIL rand_ready_it%0d: got rdy=%b free=%0d drdy=%b, need %b %0d done_hpu=%0d",
                         it, task_ready_o, free_count_o, hpu_done_ready_o, exp_rdy,
                         popc(en & ~m_busy), j);
            end
            @(negedge clk_i);
            task_valid_i     = 1'b0;
            hpu_done_valid_i = '0;
            if (want_done) m_busy[j] = 1'b0;
            if (acc) begin
                m_busy[t] = 1'b1;
                m_rr      = (t + 1) % N;
            end
            #1;
            n_tests++;
            if (busy_o !== m_busy ||
                (want_done && (feedback_valid_o !== 1'b1 || feedback_descr_o !== fd)) ||
                (acc && (onehot_idx(hpu_task_valid_o) !== t || hpu_task_descr_o[t*TW +: TW] !== d)) ||
                (!acc && hpu_task_valid_o !== 4'b0)) begin
                n_fail++;
                $display("FAIL rand_state_it%0d: got busy=%b tv=%b fbv=%b, need busy=%b hpu=%0d acc=%b",
                         it, busy_o, hpu_task_valid_o, feedback_valid_o, m_busy, t, acc);
            end
        end
        #1;
        n_tests++;
        if (err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_err: got err=%b, need 0", err_o);
        end
    endtask

    initial begin
        test_reset();
        test_fill_and_free();
        test_enable_mask();
        test_done_merge();
        test_issue_stall();
        test_err_sticky();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
